uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Register-mapped controller for the UART receive path: configures the receiver (word length, parity mode), generates its 16x baud_pulse from a programmable divisor, and buffers received characters with their error flags in a FIFO.
- Sits between the host bus and the receiver; the receiver's push/pe/fe/bi outputs feed this block, and this block drives the receiver's baud_pulse, wls, pen, eps and stick_parity.
- 16550-style subset: RBR, IER, FCR, LCR, LSR, DLL, DLM.

Parameters:
- DEPTH, 16, RX FIFO entries; power of 2, range 4..64.
- DIV_RESET, 16'd1, divisor value loaded at reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr  in  1  register write strobe, one cycle
- rd  in  1  register read strobe, one cycle; wr and rd never both high in the same cycle
- addr  in  3  register address
- din  in  8  write data
- dout  out  8  read data, registered
- rx_push  in  1  receiver character-done strobe
- rx_data  in  8  received character, valid with rx_push
- rx_pe, rx_fe, rx_bi  in  1 each  receiver error flags, valid with rx_push
- baud_pulse  out  1  16x oversample strobe to the receiver
- wls  out  2  LCR[1:0]
- pen  out  1  LCR[3]
- eps  out  1  LCR[4]
- stick_parity  out  1  LCR[5]
- irq  out  1  interrupt, level-high

Behaviour:
- Reset values:
  - dout=0, irq=0, baud_pulse=0
  - LCR=0x03, so wls=2'b11, pen=0, eps=0, stick_parity=0
  - IER=0, FCR trigger=00
  - FIFO empty, LSR sticky bits=0
  - divisor=DIV_RESET
- DLAB=LCR[7]. Register map:
  - 0: read RBR (DLAB=0) or DLL (DLAB=1); write DLL when DLAB=1, otherwise the write is ignored.
  - 1: IER (DLAB=0) or DLM (DLAB=1). IER uses only bits [0] ERBFI and [2] ELSI; other bits read 0.
  - 2: FCR, write-only, reads 0. din[1]=1 flushes the FIFO (pointers and count to 0). din[7:6] set the trigger level: 00→1, 01→4, 10→8, 11→14. When DEPTH<14 the trigger saturates at DEPTH.
  - 3: LCR, read/write, all 8 bits.
  - 5: LSR, read-only. [0] DR=FIFO not empty, [1] OE, [2] PE, [3] FE, [4] BI, others 0.
  - Other addresses read 0; writes to them are ignored.
- Read latency: dout updates on the clock edge that samples rd=1 and is valid the following cycle.
- RBR read: returns the head data and pops one entry. On an empty FIFO it returns 0x00 with no pointer change.
- Baud generator:
  - 16-bit down-counter reloaded with {DLM,DLL}-1.
  - baud_pulse is high for exactly one clk cycle when the counter is 0, then the counter reloads. Period = divisor clk cycles.
  - Divisor 1 gives baud_pulse continuously high. Divisor 0 gives no pulses, counter held.
  - Any write to DLL or DLM reloads the counter on the next cycle.
- FIFO:
  - Each entry is 11 bits: {bi,fe,pe,data}. Circular pointers of log2(DEPTH) bits wrap naturally; count is log2(DEPTH)+1 bits.
  - On rx_push with FIFO not full: write the entry and set the sticky PE/FE/BI bits from the rx flags.
  - On rx_push with FIFO full: drop the character and set OE. If an RBR pop occurs in the same cycle, the push is accepted and OE is not set.
  - Simultaneous push and pop on an empty FIFO: the pop returns 0x00 and the push is written.
  - FCR flush in the same cycle as rx_push: flush wins and the character is dropped.
- LSR read returns the current value, then clears OE/PE/FE/BI. A set event in the same cycle as the LSR read leaves the bit set.
- irq is registered and equals (ERBFI && count>=trigger) || (ELSI && (OE|PE|FE|BI)).
- Reset asserted mid-character or mid-read: all state returns to reset values asynchronously. The partially read dout is cleared.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - A 10-bit counter counts baud_pulse strobes while the FIFO is non-empty.
  - The counter clears on any push, pop or flush, and whenever the FIFO is empty.
  - When it reaches 640 (4 char times x 10 bits x 16), the sticky timeout flag sets. The flag clears on the next RBR read or flush.
  - irq also asserts on ERBFI && timeout.
- Undefined: no counter, no timeout term; irq is as above.

Test Plan:
- Reset, then read LCR → 0x03; read LSR → 0x00; irq=0. DLL=0x04, DLM=0x00 → baud_pulse high 1 cycle every 4 clk.
- LCR=0x1B → wls=11, pen=1, eps=1, stick=0. LCR=0x83, then write addr0=0x0A, addr1=0x00 → divisor 10. Clear DLAB and confirm IER is distinct from DLM.
- Push 0x45, 0xA5, 0x3C (no errors), then 3 RBR reads → 0x45, 0xA5, 0x3C in order; DR=1 until the third read, then DR=0. A fourth read → 0x00.
- Push DEPTH+1 characters → first DEPTH retained, LSR=0x03. Second LSR read → 0x01. Push and pop in the same cycle while full → OE stays 0.
- Push with rx_pe=1, then with rx_fe=1 and rx_bi=1; IER=0x04 → irq=1. LSR reads 0x1D, then irq=0. FCR=0x02 → DR=0.
- FCR=0x40, IER=0x01: pushes 1-3 → irq=0, push 4 → irq=1, one pop → irq=0. With UART_RX_TIMEOUT_EN: one char held for 640 baud_pulses → irq=1; RBR read → irq=0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: host-side register block for the UART receive path.
// Holds LCR/IER/FCR/divisor, generates the 16x baud strobe, and buffers
// received characters with their error flags in a circular FIFO.
// Optional receive timeout detection is compiled in with UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DIV_RESET = 16'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       rd,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rx_push,
  input  logic [7:0] rx_data,
  input  logic       rx_pe,
  input  logic       rx_fe,
  input  logic       rx_bi,
  output logic       baud_pulse,
  output logic [1:0] wls,
  output logic       pen,
  output logic       eps,
  output logic       stick_parity,
  output logic       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [7:0]    lcr;
  logic [7:0]    dll;
  logic [7:0]    dlm;
  logic          erbfi;
  logic          elsi;
  logic [1:0]    trig;
  logic          div_wr;
  logic [15:0]   bcnt;
  logic [15:0]   div;

  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic          oe, pe, fe, bi;
  logic          dlab;
  logic          empty;
  logic          full;
  logic          rbr_rd;
  logic          lsr_rd;
  logic          pop;
  logic          flush;
  logic          push_ok;
  logic          oe_set;
  logic [7:0]    lsr;
  logic          to_irq;

  // Trigger level for the FIFO interrupt, saturated at the FIFO depth.
  function automatic logic [6:0] trig_level(input logic [1:0] t);
    logic [6:0] l;
    case (t)
      2'b00:   l = 7'd1;
      2'b01:   l = 7'd4;
      2'b10:   l = 7'd8;
      default: l = 7'd14;
    endcase
    if (int'(l) > DEPTH) l = 7'(DEPTH);
    return l;
  endfunction

  assign dlab         = lcr[7];
  assign wls          = lcr[1:0];
  assign pen          = lcr[3];
  assign eps          = lcr[4];
  assign stick_parity = lcr[5];
  assign div          = {dlm, dll};

  assign empty   = (count == '0);
  assign full    = (int'(count) == DEPTH);
  assign rbr_rd  = rd && (addr == 3'd0) && !dlab;
  assign lsr_rd  = rd && (addr == 3'd5);
  assign pop     = rbr_rd && !empty;
  assign flush   = wr && (addr == 3'd2) && din[1];
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push_ok = rx_push && !flush && (!full || pop);
  assign oe_set  = rx_push && !flush && full && !pop;
  assign lsr     = {3'b000, bi, fe, pe, oe, !empty};

  // Host register writes; flags a divisor write so the counter reloads next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcr    <= 8'h03;
      dll    <= DIV_RESET[7:0];
      dlm    <= DIV_RESET[15:8];
      erbfi  <= 1'b0;
      elsi   <= 1'b0;
      trig   <= 2'b00;
      div_wr <= 1'b0;
    end else begin
      div_wr <= 1'b0;
      if (wr) begin
        case (addr)
          3'd0: if (dlab) begin
            dll    <= din;
            div_wr <= 1'b1;
          end
          3'd1: if (dlab) begin
            dlm    <= din;
            div_wr <= 1'b1;
          end else begin
            erbfi  <= din[0];
            elsi   <= din[2];
          end
          3'd2: trig <= din[7:6];
          3'd3: lcr  <= din;
          default: ;
        endcase
      end
    end
  end

  // Baud down-counter: one-cycle strobe at zero, then reload with divisor-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt       <= DIV_RESET - 16'd1;
      baud_pulse <= 1'b0;
    end else if (div_wr) begin
      bcnt       <= div - 16'd1;
      baud_pulse <= 1'b0;
    end else if (div == 16'd0) begin
      baud_pulse <= 1'b0;
    end else if (bcnt == 16'd0) begin
      bcnt       <= div - 16'd1;
      baud_pulse <= 1'b1;
    end else begin
      bcnt       <= bcnt - 16'd1;
      baud_pulse <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= {rx_bi, rx_fe, rx_pe, rx_data};
  end

  // FIFO pointers and occupancy; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Sticky line-status bits: cleared by an LSR read unless set in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe <= 1'b0;
      pe <= 1'b0;
      fe <= 1'b0;
      bi <= 1'b0;
    end else begin
      oe <= oe_set             | (oe & !lsr_rd);
      pe <= (push_ok && rx_pe) | (pe & !lsr_rd);
      fe <= (push_ok && rx_fe) | (fe & !lsr_rd);
      bi <= (push_ok && rx_bi) | (bi & !lsr_rd);
    end
  end

  // Registered read data, captured on the edge that samples rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 8'h00;
    end else if (rd) begin
      case (addr)
        3'd0:    dout <= dlab ? dll : (empty ? 8'h00 : mem[rptr][7:0]);
        3'd1:    dout <= dlab ? dlm : {5'b00000, elsi, 1'b0, erbfi};
        3'd3:    dout <= lcr;
        3'd5:    dout <= lsr;
        default: dout <= 8'h00;
      endcase
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [9:0] tcnt;
  logic       timeout;

  // Character timeout: counts baud strobes while data sits idle in the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      if (push_ok || pop || flush || empty) tcnt <= '0;
      else if (baud_pulse && (tcnt != 10'd640)) tcnt <= tcnt + 10'd1;
      if (rbr_rd || flush) timeout <= 1'b0;
      else if (tcnt == 10'd640) timeout <= 1'b1;
    end
  end

  assign to_irq = erbfi && timeout;
`else
  assign to_irq = 1'b0;
`endif

  // Level interrupt from the FIFO threshold, line status and optional timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= (erbfi && (7'(count) >= trig_level(trig))) ||
             (elsi && (oe || pe || fe || bi)) ||
             to_irq;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl (DEPTH=16, DIV_RESET=1).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       rx_push = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_pe = 1'b0;
  logic       rx_fe = 1'b0;
  logic       rx_bi = 1'b0;
  logic       baud_pulse;
  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       stick_parity;
  logic       irq;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(16), .DIV_RESET(16'd1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .rd           (rd),
    .addr         (addr),
    .din          (din),
    .dout         (dout),
    .rx_push      (rx_push),
    .rx_data      (rx_data),
    .rx_pe        (rx_pe),
    .rx_fe        (rx_fe),
    .rx_bi        (rx_bi),
    .baud_pulse   (baud_pulse),
    .wls          (wls),
    .pen          (pen),
    .eps          (eps),
    .stick_parity (stick_parity),
    .irq          (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
    d = dout;
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic f, input logic b);
    rx_push = 1'b1; rx_data = d; rx_pe = p; rx_fe = f; rx_bi = b;
    @(negedge clk);
    rx_push = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0; rx_bi = 1'b0;
  endtask

  // Cycles between consecutive baud strobes; -1 when no strobe arrives within the bound.
  task automatic measure_period(output int per);
    int k;
    per = -1;
    k = 0;
    while (baud_pulse !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (baud_pulse === 1'b1) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (baud_pulse !== 1'b1 && k < 64);
      if (baud_pulse === 1'b1) per = k;
    end
  endtask

  initial begin
    logic [7:0] v;
    int         per;

    // Reset state
    #12;
    check("rst_dout", dout, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_baud", baud_pulse, 1'b0);
    check("rst_wls", wls, 2'b11);
    check("rst_pen", pen, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("div1_baud_high", baud_pulse, 1'b1);
    idle(1);
    check("div1_baud_still_high", baud_pulse, 1'b1);
    reg_rd(3'd3, v); check("lcr_reset", v, 8'h03);
    reg_rd(3'd5, v); check("lsr_reset", v, 8'h00);
    check("irq_idle", irq, 1'b0);

    // Divisor 4
    reg_wr(3'd3, 8'h83);
    reg_wr(3'd0, 8'h04);
    reg_wr(3'd1, 8'h00);
    reg_wr(3'd3, 8'h03);
    measure_period(per); check("baud_period_4", 32'(per), 32'd4);

    // LCR fields
    reg_wr(3'd3, 8'h1B);
    check("wls_1b", wls, 2'b11);
    check("pen_1b", pen, 1'b1);
    check("eps_1b", eps, 1'b1);
    check("stick_1b", stick_parity, 1'b0);
    reg_wr(3'd3, 8'h2A);
    check("wls_2a", wls, 2'b10);
    check("stick_2a", stick_parity, 1'b1);
    check("eps_2a", eps, 1'b0);

    // Divisor 10 through DLAB, and DLL write ignored without DLAB
    reg_wr(3'd3, 8'h83);
    reg_wr(3'd0, 8'h0A);
    reg_wr(3'd1, 8'h00);
    reg_rd(3'd0, v); check("dll_rd", v, 8'h0A);
    reg_rd(3'd1, v); check("dlm_rd", v, 8'h00);
    reg_rd(3'd3, v); check("lcr_83", v, 8'h83);
    measure_period(per); check("baud_period_10", 32'(per), 32'd10);
    reg_wr(3'd3, 8'h03);
    reg_wr(3'd0, 8'h55);
    reg_wr(3'd1, 8'hFF);
    reg_rd(3'd1, v); check("ier_mask", v, 8'h05);
    reg_rd(3'd2, v); check("fcr_reads_0", v, 8'h00);
    reg_rd(3'd4, v); check("addr4_reads_0", v, 8'h00);
    reg_wr(3'd3, 8'h83);
    reg_rd(3'd1, v); check("dlm_distinct", v, 8'h00);
    reg_rd(3'd0, v); check("dll_not_overwritten", v, 8'h0A);
    reg_wr(3'd3, 8'h03);
    reg_wr(3'd1, 8'h00);

    // FIFO order
    push(8'h45, 1'b0, 1'b0, 1'b0);
    push(8'hA5, 1'b0, 1'b0, 1'b0);
    push(8'h3C, 1'b0, 1'b0, 1'b0);
    reg_rd(3'd5, v); check("lsr_dr_3", v, 8'h01);
    reg_rd(3'd0, v); check("rbr_0", v, 8'h45);
    reg_rd(3'd5, v); check("lsr_dr_2", v, 8'h01);
    reg_rd(3'd0, v); check("rbr_1", v, 8'hA5);
    reg_rd(3'd5, v); check("lsr_dr_1", v, 8'h01);
    reg_rd(3'd0, v); check("rbr_2", v, 8'h3C);
    reg_rd(3'd5, v); check("lsr_empty", v, 8'h00);
    reg_rd(3'd0, v); check("rbr_empty", v, 8'h00);

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    reg_rd(3'd5, v); check("lsr_oe", v, 8'h03);
    reg_rd(3'd5, v); check("lsr_oe_cleared", v, 8'h01);
    rx_push = 1'b1; rx_data = 8'h77; rd = 1'b1; addr = 3'd0;
    @(negedge clk);
    rx_push = 1'b0; rd = 1'b0;
    check("full_pushpop_rd", dout, 8'h10);
    reg_rd(3'd5, v); check("full_pushpop_no_oe", v, 8'h01);
    for (int i = 1; i < 16; i++) begin
      reg_rd(3'd0, v); check("drain", v, 8'h10 + 8'(i));
    end
    reg_rd(3'd0, v); check("drain_last", v, 8'h77);
    reg_rd(3'd5, v); check("drain_empty", v, 8'h00);

    // Error flags and line-status interrupt
    push(8'h01, 1'b1, 1'b0, 1'b0);
    push(8'h02, 1'b0, 1'b1, 1'b1);
    idle(2);
    check("irq_elsi_off", irq, 1'b0);
    reg_wr(3'd1, 8'h04);
    idle(1);
    check("irq_elsi_on", irq, 1'b1);
    reg_rd(3'd5, v); check("lsr_errors", v, 8'h1D);
    idle(1);
    check("irq_after_lsr", irq, 1'b0);
    reg_rd(3'd5, v); check("lsr_err_cleared", v, 8'h01);
    reg_wr(3'd2, 8'h02);
    reg_rd(3'd5, v); check("lsr_flushed", v, 8'h00);
    reg_wr(3'd1, 8'h00);

    // Flush in the same cycle as a push drops the character
    rx_push = 1'b1; rx_data = 8'h99; rx_pe = 1'b1;
    wr = 1'b1; addr = 3'd2; din = 8'h02;
    @(negedge clk);
    rx_push = 1'b0; rx_pe = 1'b0; wr = 1'b0;
    reg_rd(3'd5, v); check("flush_beats_push", v, 8'h00);

    // Trigger level 4
    reg_wr(3'd2, 8'h40);
    reg_wr(3'd1, 8'h01);
    for (int i = 1; i <= 3; i++) begin
      push(8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
      idle(1);
      check("irq_below_trig", irq, 1'b0);
    end
    push(8'h34, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("irq_at_trig", irq, 1'b1);
    reg_rd(3'd0, v); check("trig_pop", v, 8'h31);
    idle(1);
    check("irq_after_pop", irq, 1'b0);
    reg_wr(3'd2, 8'h42);
    reg_wr(3'd1, 8'h00);

`ifdef UART_RX_TIMEOUT_EN
    // Receive timeout with divisor 1 (one strobe per clock)
    reg_wr(3'd3, 8'h83);
    reg_wr(3'd0, 8'h01);
    reg_wr(3'd1, 8'h00);
    reg_wr(3'd3, 8'h03);
    reg_wr(3'd1, 8'h01);
    push(8'h66, 1'b0, 1'b0, 1'b0);
    idle(600);
    check("timeout_not_yet", irq, 1'b0);
    idle(60);
    check("timeout_irq", irq, 1'b1);
    reg_rd(3'd0, v); check("timeout_rbr", v, 8'h66);
    idle(1);
    check("timeout_cleared", irq, 1'b0);
    reg_wr(3'd1, 8'h00);
`endif

    // Reset in the middle of a read
    push(8'h5A, 1'b0, 1'b0, 1'b0);
    reg_wr(3'd3, 8'h1F);
    rd = 1'b1; addr = 3'd0;
    @(posedge clk);
    #1;
    check("midread_dout", dout, 8'h5A);
    rst_n = 1'b0;
    #1;
    check("midread_rst_dout", dout, 8'h00);
    check("midread_rst_pen", pen, 1'b0);
    check("midread_rst_wls", wls, 2'b11);
    rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reg_rd(3'd5, v); check("midread_rst_lsr", v, 8'h00);
    reg_rd(3'd3, v); check("midread_rst_lcr", v, 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
